// File: rtl/imem_load_run_ctrl.sv
// Load/run sequencer for a single-cycle RISC-V core: streams a host image into
// instruction memory while the core is held in reset, then gates core progress.
module imem_load_run_ctrl #(
    parameter int          ADDR_W     = 8,
    parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              run_cmd,
    input  logic              step_cmd,
    input  logic              halt_cmd,
    input  logic              reload_cmd,
    input  logic [31:0]       instr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rstn,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   load_count,
    output logic              load_ovf,
    output logic              halted_ebreak,
    output logic [31:0]       retired
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   load_count_reg, load_count_next;
    logic              load_ovf_reg, load_ovf_next;
    logic              halted_ebreak_reg, halted_ebreak_next;
    logic [31:0]       retired_reg, retired_next;
    logic              accept;
    logic              at_halt_instr;

    // load_count never exceeds the depth, so its MSB alone flags a full memory
    assign load_ready    = (state_reg == ST_LOAD) && !load_count_reg[ADDR_W];
    assign accept        = load_valid && load_ready;
    assign at_halt_instr = (instr == HALT_INSTR);

    assign imem_we       = accept;
    assign imem_waddr    = load_count_reg[ADDR_W-1:0];
    assign imem_wdata    = load_data;
    assign cpu_rstn      = (state_reg != ST_LOAD);
    assign cpu_en        = ((state_reg == ST_RUN) || (state_reg == ST_STEP)) && !at_halt_instr;

    assign state         = state_reg;
    assign load_count    = load_count_reg;
    assign load_ovf      = load_ovf_reg;
    assign halted_ebreak = halted_ebreak_reg;
    assign retired       = retired_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg         <= ST_LOAD;
            load_count_reg    <= '0;
            load_ovf_reg      <= 1'b0;
            halted_ebreak_reg <= 1'b0;
            retired_reg       <= '0;
        end else begin
            state_reg         <= state_next;
            load_count_reg    <= load_count_next;
            load_ovf_reg      <= load_ovf_next;
            halted_ebreak_reg <= halted_ebreak_next;
            retired_reg       <= retired_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        load_count_next    = load_count_reg;
        load_ovf_next      = load_ovf_reg;
        halted_ebreak_next = halted_ebreak_reg;
        retired_next       = retired_reg + 32'(cpu_en);

        case (state_reg)
            ST_LOAD: begin
                if (accept)
                    load_count_next = load_count_reg + 1'b1;
                if (load_valid && !load_ready)
                    load_ovf_next = 1'b1;
                // run only counts once at least one word (this cycle's included) is in
                if (accept && load_last)
                    state_next = ST_HALT;
                else if (run_cmd && !reload_cmd && (load_count_next != '0))
                    state_next = ST_RUN;
            end
            ST_HALT: begin
                if (reload_cmd) begin
                    state_next         = ST_LOAD;
                    load_count_next    = '0;
                    load_ovf_next      = 1'b0;
                    halted_ebreak_next = 1'b0;
                end else if (halt_cmd) begin
                    state_next = ST_HALT;
                end else if (step_cmd) begin
                    state_next         = ST_STEP;
                    halted_ebreak_next = 1'b0;
                end else if (run_cmd) begin
                    state_next         = ST_RUN;
                    halted_ebreak_next = 1'b0;
                end
            end
            ST_RUN: begin
                if (reload_cmd) begin
                    state_next         = ST_LOAD;
                    load_count_next    = '0;
                    load_ovf_next      = 1'b0;
                    halted_ebreak_next = 1'b0;
                end else if (halt_cmd) begin
                    state_next = ST_HALT;
                end else if (at_halt_instr) begin
                    state_next         = ST_HALT;
                    halted_ebreak_next = 1'b1;
                end
            end
            default: begin
                if (reload_cmd) begin
                    state_next         = ST_LOAD;
                    load_count_next    = '0;
                    load_ovf_next      = 1'b0;
                    halted_ebreak_next = 1'b0;
                end else begin
                    state_next         = ST_HALT;
                    halted_ebreak_next = at_halt_instr;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_imem_load_run_ctrl.sv
// Bench for imem_load_run_ctrl: directed vector table, async-reset sequence and
// random stimulus checked against a behavioural model (4-word memory).
module tb_imem_load_run_ctrl;

    localparam int          AW    = 2;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] EBRK  = 32'h00100073;
    localparam logic [3:0]  C_N   = 4'b0000;   // {reload, halt, step, run}
    localparam logic [3:0]  C_RUN = 4'b0001;
    localparam logic [3:0]  C_STP = 4'b0010;
    localparam logic [3:0]  C_HLT = 4'b0100;
    localparam logic [3:0]  C_RLD = 4'b1000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          load_valid = 1'b0;
    logic [31:0]   load_data = '0;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic          run_cmd = 1'b0, step_cmd = 1'b0, halt_cmd = 1'b0, reload_cmd = 1'b0;
    logic [31:0]   instr = '0;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_rstn, cpu_en;
    logic [1:0]    state;
    logic [AW:0]   load_count;
    logic          load_ovf, halted_ebreak;
    logic [31:0]   retired;

    int n_checks = 0;
    int n_fail   = 0;

    imem_load_run_ctrl #(.ADDR_W(AW), .HALT_INSTR(EBRK)) dut (
        .clk(clk), .rstn(rstn),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready),
        .run_cmd(run_cmd), .step_cmd(step_cmd), .halt_cmd(halt_cmd), .reload_cmd(reload_cmd),
        .instr(instr),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_rstn(cpu_rstn), .cpu_en(cpu_en), .state(state),
        .load_count(load_count), .load_ovf(load_ovf), .halted_ebreak(halted_ebreak),
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          lv;
        logic [31:0] ld;
        bit          ll;
        logic [3:0]  cmd;
        logic [31:0] ins;
        bit          we;
        int          wa;
        bit          rdy;
        bit          rs;
        bit          en;
        int          st;
        int          cnt;
        bit          ovf;
        bit          eb;
        int          ret;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit lv, input logic [31:0] ld, input bit ll, input logic [3:0] cmd,
                       input logic [31:0] ins, input bit we, input int wa, input bit rdy,
                       input bit rs, input bit en, input int st, input int cnt, input bit ovf,
                       input bit eb, input int ret);
        vec_t v;
        v = '{lv, ld, ll, cmd, ins, we, wa, rdy, rs, en, st, cnt, ovf, eb, ret};
        vecs.push_back(v);
    endtask

    task automatic drive(input bit lv, input logic [31:0] ld, input bit ll,
                         input logic [3:0] cmd, input logic [31:0] ins);
        load_valid = lv;
        load_data  = ld;
        load_last  = ll;
        {reload_cmd, halt_cmd, step_cmd, run_cmd} = cmd;
        instr      = ins;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic [7:0]  exp_comb;
        logic [36:0] exp_regs;
        @(negedge clk);
        drive(v.lv, v.ld, v.ll, v.cmd, v.ins);
        #1;
        exp_comb = {v.we, 2'(v.wa), v.rdy, v.rs, v.en, 2'(v.st)};
        chk($sformatf("vec%0d we/waddr/ready/cpu_rstn/cpu_en/state", idx),
            64'({imem_we, imem_waddr, load_ready, cpu_rstn, cpu_en, state}), 64'(exp_comb));
        if (v.we)
            chk($sformatf("vec%0d wdata", idx), 64'(imem_wdata), 64'(v.ld));
        @(posedge clk);
        #1;
        exp_regs = {3'(v.cnt), v.ovf, v.eb, 32'(v.ret)};
        chk($sformatf("vec%0d load_count/ovf/ebreak/retired", idx),
            64'({load_count, load_ovf, halted_ebreak, retired}), 64'(exp_regs));
    endtask

    // behavioural model state: mode uses the visible state code
    int          m_mode, m_cnt, m_ret;
    bit          m_ovf, m_eb;

    initial begin
        // stream 4 words, last on the 4th
        add(1, 32'h00100093, 0, C_N, 0,            1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 32'h00200113, 0, C_N, 0,            1, 1, 1, 0, 0, 0, 2, 0, 0, 0);
        add(1, 32'h002081b3, 0, C_N, 0,            1, 2, 1, 0, 0, 0, 3, 0, 0, 0);
        add(1, 32'h00100073, 1, C_N, 0,            1, 3, 1, 0, 0, 0, 4, 0, 0, 0);
        add(0, 0, 0, C_N,   32'h00100093,          0, 0, 0, 1, 0, 3, 4, 0, 0, 0);
        // run three instructions into EBREAK
        add(0, 0, 0, C_RUN, 32'h00100093,          0, 0, 0, 1, 0, 3, 4, 0, 0, 0);
        add(0, 0, 0, C_N,   32'h00100093,          0, 0, 0, 1, 1, 1, 4, 0, 0, 1);
        add(0, 0, 0, C_N,   32'h00200113,          0, 0, 0, 1, 1, 1, 4, 0, 0, 2);
        add(0, 0, 0, C_N,   32'h002081b3,          0, 0, 0, 1, 1, 1, 4, 0, 0, 3);
        add(0, 0, 0, C_N,   EBRK,                  0, 0, 0, 1, 0, 1, 4, 0, 1, 3);
        add(0, 0, 0, C_N,   EBRK,                  0, 0, 0, 1, 0, 3, 4, 0, 1, 3);
        // step on EBREAK re-detects it without advancing
        add(0, 0, 0, C_STP, EBRK,                  0, 0, 0, 1, 0, 3, 4, 0, 0, 3);
        add(0, 0, 0, C_N,   EBRK,                  0, 0, 0, 1, 0, 2, 4, 0, 1, 3);
        // reload, two words, run, halt beats step, single step
        add(0, 0, 0, C_RLD, EBRK,                  0, 0, 0, 1, 0, 3, 0, 0, 0, 3);
        add(1, 32'h11, 0, C_N, 32'h13,             1, 0, 1, 0, 0, 0, 1, 0, 0, 3);
        add(1, 32'h22, 0, C_N, 32'h13,             1, 1, 1, 0, 0, 0, 2, 0, 0, 3);
        add(0, 0, 0, C_RUN, 32'h13,                0, 2, 1, 0, 0, 0, 2, 0, 0, 3);
        add(0, 0, 0, C_STP | C_HLT, 32'h13,        0, 2, 0, 1, 1, 1, 2, 0, 0, 4);
        add(0, 0, 0, C_STP, 32'h13,                0, 2, 0, 1, 0, 3, 2, 0, 0, 4);
        add(0, 0, 0, C_N,   32'h13,                0, 2, 0, 1, 1, 2, 2, 0, 0, 5);
        add(0, 0, 0, C_N,   32'h13,                0, 2, 0, 1, 0, 3, 2, 0, 0, 5);
        // run with an empty image is ignored
        add(0, 0, 0, C_RLD, 32'h13,                0, 2, 0, 1, 0, 3, 0, 0, 0, 5);
        add(0, 0, 0, C_RUN, 32'h13,                0, 0, 1, 0, 0, 0, 0, 0, 0, 5);
        add(0, 0, 0, C_N,   32'h13,                0, 0, 1, 0, 0, 0, 0, 0, 0, 5);
        // six words into a four-word memory
        for (int i = 0; i < 6; i++) begin
            if (i < DEPTH)
                add(1, 32'hA0 + 32'(i), 0, C_N, 32'h13, 1, i, 1, 0, 0, 0, i + 1, 0, 0, 5);
            else
                add(1, 32'hA0 + 32'(i), 0, C_N, 32'h13, 0, 0, 0, 0, 0, 0, 4, 1, 0, 5);
        end
        // run, then reload mid-run
        add(0, 0, 0, C_RUN, 32'h13,                0, 0, 0, 0, 0, 0, 4, 1, 0, 5);
        add(0, 0, 0, C_RLD, EBRK,                  0, 0, 0, 1, 0, 1, 0, 0, 0, 5);
        add(0, 0, 0, C_N,   32'h13,                0, 0, 1, 0, 0, 0, 0, 0, 0, 5);

        // reset values
        #1;
        chk("reset state",      64'(state), 64'(0));
        chk("reset load_count", 64'(load_count), 64'(0));
        chk("reset flags",      64'({load_ovf, halted_ebreak}), 64'(0));
        chk("reset retired",    64'(retired), 64'(0));
        chk("reset comb",       64'({cpu_rstn, cpu_en, load_ready, imem_we}), 64'(4'b0010));
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // asynchronous reset in the middle of RUN
        @(negedge clk); drive(1, 32'h13, 1, C_N, 32'h13);
        @(negedge clk); drive(0, 0, 0, C_RUN, 32'h13);
        @(negedge clk); drive(0, 0, 0, C_N, 32'h13);
        @(posedge clk);
        #3;
        chk("pre-async state",   64'(state), 64'(1));
        chk("pre-async retired", 64'(retired), 64'(6));
        rstn = 1'b0;
        #1;
        chk("async state",      64'(state), 64'(0));
        chk("async cpu_rstn/en", 64'({cpu_rstn, cpu_en}), 64'(0));
        chk("async retired",    64'(retired), 64'(0));
        chk("async load_count", 64'(load_count), 64'(0));
        @(negedge clk);
        rstn = 1'b1;

        // random stimulus against the model
        m_mode = 0; m_cnt = 0; m_ret = 0; m_ovf = 0; m_eb = 0;
        for (int c = 0; c < 3000 && n_fail < 20; c++) begin
            bit          lv, ll, e_rdy, e_we, e_en, is_eb;
            logic [3:0]  cmd;
            logic [31:0] ins;
            int          r;
            lv  = ($urandom_range(0, 1) == 1);
            ll  = ($urandom_range(0, 5) == 0);
            ins = ($urandom_range(0, 4) == 0) ? EBRK : $urandom;
            r   = $urandom_range(0, 11);
            cmd = (r < 4) ? 4'(1 << r) : C_N;
            if (m_mode == 0 && cmd == C_RLD) cmd = C_N;
            @(negedge clk);
            drive(lv, $urandom, ll, cmd, ins);
            #1;
            is_eb = (ins == EBRK);
            e_rdy = (m_mode == 0) && (m_cnt < DEPTH);
            e_we  = e_rdy && lv;
            e_en  = (m_mode == 1 || m_mode == 2) && !is_eb;
            chk($sformatf("rnd%0d comb", c),
                64'({imem_we, load_ready, cpu_rstn, cpu_en, state}),
                64'({e_we, e_rdy, (m_mode != 0), e_en, 2'(m_mode)}));
            if (e_we)
                chk($sformatf("rnd%0d waddr/wdata", c), 64'({imem_waddr, imem_wdata}),
                    64'({2'(m_cnt % DEPTH), load_data}));
            m_ret = m_ret + int'(e_en);
            if (cmd == C_RLD && m_mode != 0) begin
                m_mode = 0; m_cnt = 0; m_ovf = 0; m_eb = 0;
            end else if (m_mode == 0) begin
                if (e_we) m_cnt++;
                if (lv && !e_rdy) m_ovf = 1;
                if (e_we && ll) m_mode = 3;
                else if (cmd == C_RUN && m_cnt > 0) m_mode = 1;
            end else if (m_mode == 3) begin
                if (cmd == C_STP) begin m_mode = 2; m_eb = 0; end
                else if (cmd == C_RUN) begin m_mode = 1; m_eb = 0; end
            end else if (m_mode == 1) begin
                if (cmd == C_HLT) m_mode = 3;
                else if (is_eb) begin m_mode = 3; m_eb = 1; end
            end else begin
                m_mode = 3;
                m_eb = is_eb;
            end
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d regs", c),
                64'({load_count, load_ovf, halted_ebreak, retired}),
                64'({3'(m_cnt), m_ovf, m_eb, 32'(m_ret)}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_load_run_ctrl.md
Name: imem_load_run_ctrl

Overview:
- Sequences the single-cycle RISC-V core and shares its instruction memory between a host program loader and CPU fetch.
- While loading, holds the core in reset and streams host words into instruction memory over a valid/ready handshake.
- After loading, releases reset and gates core progress with run / single-step / halt control.
- Stops automatically on EBREAK and counts executed instructions.

Parameters:
ADDR_W, 8, instruction-memory word-address width (depth = 2^ADDR_W words)
HALT_INSTR, 32'h00100073, encoding that stops RUN (EBREAK)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
load_valid  input  1  host word available
load_data  input  32  host instruction word
load_last  input  1  qualifies final word of the image (sampled with load_valid)
load_ready  output  1  controller accepts a word this cycle
run_cmd  input  1  one-cycle pulse: free-run
step_cmd  input  1  one-cycle pulse: execute one instruction
halt_cmd  input  1  one-cycle pulse: stop
reload_cmd  input  1  one-cycle pulse: return to LOAD
instr  input  32  instruction currently fetched at core PC
imem_we  output  1  instruction-memory write enable
imem_waddr  output  ADDR_W  instruction-memory word write address
imem_wdata  output  32  instruction-memory write data
cpu_rstn  output  1  active-low reset to core (0 = core held in reset, PC=0)
cpu_en  output  1  core advance enable (PC/regfile update this cycle)
state  output  2  00 LOAD, 01 RUN, 10 STEP, 11 HALT
load_count  output  ADDR_W+1  words written since last LOAD entry
load_ovf  output  1  sticky: word offered while memory full
halted_ebreak  output  1  sticky: last stop caused by HALT_INSTR
retired  output  32  count of cycles with cpu_en=1

Behaviour:
- Reset (async, rstn=0) values:
  - state=LOAD, load_count=0, load_ovf=0, halted_ebreak=0, retired=0.
  - Hence cpu_rstn=0, cpu_en=0, load_ready=1, imem_we=0.
- All state updates occur on the rising edge of clk.
- The outputs imem_we/waddr/wdata, load_ready, cpu_rstn and cpu_en are combinational from state/registers/inputs.
- load_ready = (state==LOAD) && (load_count < 2^ADDR_W).
- Accept = load_valid && load_ready. On accept:
  - imem_we=1, imem_waddr=load_count[ADDR_W-1:0], imem_wdata=load_data, same cycle.
  - load_count increments at the edge.
- Full memory: load_valid && state==LOAD && !load_ready sets load_ovf. The word is dropped and no write occurs.
- cpu_rstn = (state != LOAD).
- cpu_en:
  - RUN: 1 iff instr != HALT_INSTR.
  - STEP: 1 iff instr != HALT_INSTR.
  - LOAD/HALT: 0.
- retired increments each edge where cpu_en=1 and wraps at 2^32.
- Command priority in every state: reload_cmd > halt_cmd > step_cmd > run_cmd.
- Transitions:
  - LOAD:
    - Accepted word with load_last=1 -> HALT.
    - Else run_cmd with load_count>0 (counting a word accepted this cycle) -> RUN.
    - run_cmd with zero words ignored.
    - halt/step ignored.
  - HALT:
    - reload_cmd -> LOAD, clearing load_count, load_ovf, halted_ebreak (retired kept).
    - step_cmd -> STEP.
    - run_cmd -> RUN.
    - Leaving HALT via run/step clears halted_ebreak.
  - RUN:
    - reload_cmd -> LOAD (core immediately back in reset).
    - halt_cmd -> HALT; the current cycle still has cpu_en per rule above.
    - instr==HALT_INSTR -> HALT with halted_ebreak=1; cpu_en=0 so PC stays at the EBREAK.
  - STEP:
    - Always exactly one cycle, then -> HALT (reload_cmd -> LOAD instead).
    - If instr==HALT_INSTR, no advance and halted_ebreak=1.
- Step latency: the step_cmd pulse is seen in HALT at edge N. The STEP cycle N..N+1 has cpu_en=1. Back in HALT at edge N+1.
- Run/step issued while stopped on EBREAK re-detects it: no advance, return to HALT, halted_ebreak=1. Software/host must reload to move past it.
- Reset asserted mid-load or mid-run aborts immediately to reset values; a partial image remains in memory but load_count=0.

Test Plan:
1. Reset, stream 4 words (0x00100093, 0x00200113, 0x002081b3, 0x00100073, last on 4th) with continuous load_valid -> writes to addr 0..3 on consecutive cycles, load_count=4, state=HALT, cpu_rstn=1, cpu_en=0.
2. Following (1), run_cmd -> state RUN, cpu_en=1 for 3 cycles. instr=0x00100073 -> cpu_en=0, state HALT, halted_ebreak=1, retired=3.
3. Reload, load 2 words without last, then run_cmd -> RUN. Inject step_cmd and halt_cmd together -> HALT (halt wins). step_cmd -> exactly one cpu_en cycle, retired +1, back to HALT.
4. ADDR_W=2, offer 6 words without last -> 4 writes (addr 0..3), load_ready=0 after 4th, load_ovf=1, no further imem_we.
5. run_cmd in LOAD with load_count=0 -> stays LOAD. reload_cmd during RUN -> same-edge transition to LOAD, cpu_rstn=0, load_count=0, retired unchanged.
6. Assert rstn=0 asynchronously mid-RUN (between edges) -> state LOAD, cpu_rstn=0, retired=0 immediately, without waiting for clk.
